vga_sync_decoder: RTL and testbench

Receive-side companion to the VGA timing generator. Decodes an incoming hsync/vsync pair, in the same 25 MHz domain, back into pixel coordinates. Measures the line and frame periods against the configured 640x480 timing and runs a lock state machine. Sits in the capture/self-check path and gives the scope's pixel pipeline and BIST logic x/y, video_active and lock status without access to the generator's counters.

---
 rtl/vga_sync_decoder.sv | 173 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and a lock indication from an incoming hsync/vsync pair.
// Define VGA_DEC_ERR_CNT_EN to build the saturating loss-of-lock counter on err_count.
module vga_sync_decoder #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int LOCK_FRAMES     = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        video_active,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_error,
    output logic [15:0] err_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HOFF    = H_SYNC + H_BACK;
    localparam int VOFF    = V_SYNC + V_BACK;

    localparam logic        IDLE_LEVEL = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_TIMEOUT  = 12'(2 * H_TOTAL - 1);
    localparam logic [11:0] H_START    = 12'(HOFF);
    localparam logic [11:0] H_END      = 12'(HOFF + H_VISIBLE);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_TIMEOUT  = 11'(2 * V_TOTAL - 1);
    localparam logic [10:0] V_START    = 11'(VOFF);
    localparam logic [10:0] V_END      = 11'(VOFF + V_VISIBLE);
    localparam logic [7:0]  LOCK_TARGET = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t      state;
    logic        hs_d;
    logic        vs_d;
    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_seen;
    logic [7:0]  good_cnt;

    logic        hs_edge;
    logic        vs_edge;
    logic        h_fail;
    logic        v_fail;
    logic        timeout;
    logic        check_fail;

    // Edges compare the live pin against the previous sample, so a counter
    // cleared by an edge reads 0 in the very next cycle.
    assign hs_edge = (hsync ^ IDLE_LEVEL) & ~(hs_d ^ IDLE_LEVEL);
    assign vs_edge = (vsync ^ IDLE_LEVEL) & ~(vs_d ^ IDLE_LEVEL);

    assign h_fail     = hs_edge & (h_cnt != H_LAST);
    assign v_fail     = vs_edge & (v_cnt != V_LAST);
    assign timeout    = (h_cnt >= H_TIMEOUT) | (v_cnt >= V_TIMEOUT);
    assign check_fail = h_fail | v_fail | timeout;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            hs_d   <= IDLE_LEVEL;
            vs_d   <= IDLE_LEVEL;
            h_cnt  <= '0;
            v_cnt  <= '0;
            h_seen <= 1'b0;
        end else begin
            hs_d <= hsync;
            vs_d <= vsync;
            if (hs_edge) begin
                h_cnt  <= '0;
                h_seen <= 1'b1;
            end else if (h_cnt != '1) begin
                h_cnt <= h_cnt + 12'd1;
            end
            // A vsync edge normally lands on an hsync edge; the frame restart wins.
            if (vs_edge) begin
                v_cnt <= '0;
            end else if (hs_edge && (v_cnt != '1)) begin
                v_cnt <= v_cnt + 11'd1;
            end
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNLOCKED;
            good_cnt   <= '0;
            locked     <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            sync_error <= 1'b0;
            case (state)
                UNLOCKED: begin
                    if (vs_edge && h_seen) begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                    end
                end
                ACQUIRE: begin
                    if (check_fail) begin
                        state <= UNLOCKED;
                    end else if (vs_edge) begin
                        good_cnt <= good_cnt + 8'd1;
                        if ((good_cnt + 8'd1) >= LOCK_TARGET) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (check_fail) begin
                        state      <= UNLOCKED;
                        locked     <= 1'b0;
                        sync_error <= 1'b1;
                    end
                end
                default: begin
                    state  <= UNLOCKED;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    logic        h_in;
    logic        v_in;
    logic [11:0] x_off;
    logic [10:0] y_off;

    always_comb begin
        h_in         = (h_cnt >= H_START) && (h_cnt < H_END);
        v_in         = (v_cnt >= V_START) && (v_cnt < V_END);
        x_off        = h_cnt - H_START;
        y_off        = v_cnt - V_START;
        video_active = locked & h_in & v_in;
        x            = video_active ? {4'd0, x_off} : 16'd0;
        y            = video_active ? {5'd0, y_off} : 16'd0;
        frame_start  = video_active & (h_cnt == H_START) & (v_cnt == V_START);
    end

`ifdef VGA_DEC_ERR_CNT_EN
    logic lose_lock;
    assign lose_lock = (state == LOCKED) & check_fail;

    // Counts in step with the sync_error register so both change together.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (lose_lock && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomized bench for vga_sync_decoder on a shrunken raster so that many frames fit
// in a short run; expectations come from an event-level model of sync edge timing.
module tb_vga_sync_decoder;

    localparam int HV  = 16;
    localparam int HF  = 3;
    localparam int HS  = 4;
    localparam int HB  = 5;
    localparam int VV  = 6;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int LF  = 2;
    localparam int SAL = 1;
    localparam int HT   = HV + HF + HS + HB;
    localparam int VT   = VV + VF + VS + VB;
    localparam int HOFF = HS + HB;
    localparam int VOFF = VS + VB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hsync;
    logic        vsync;
    logic [15:0] x;
    logic [15:0] y;
    logic        video_active;
    logic        frame_start;
    logic        locked;
    logic        sync_error;
    logic [15:0] err_count;

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .LOCK_FRAMES(LF), .SYNC_ACTIVE_LOW(SAL)
    ) dut (
        .clk_25MHz(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .video_active(video_active), .frame_start(frame_start),
        .locked(locked), .sync_error(sync_error), .err_count(err_count)
    );

    always #20 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Source raster position and the asserted state of the pins it drives.
    int gen_h, gen_v, line_len, frame_lines;
    bit hold_h, jitter, hs_drv, vs_drv;

    // Model: cycle timestamps of the last edges rather than running counters.
    int cyc, h_start, lines, phase, m_err, vs_edges;
    bit m_hs_prev, m_vs_prev, m_h_seen, m_sync_err;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, actual, expected);
        end
    endtask

    task automatic drive_pins();
        hs_drv = (gen_h < HS) && !hold_h;
        vs_drv = gen_v < VS;
        hsync  = (SAL != 0) ? !hs_drv : hs_drv;
        vsync  = (SAL != 0) ? !vs_drv : vs_drv;
    endtask

    task automatic advance_gen();
        gen_h++;
        if (gen_h >= line_len) begin
            gen_h = 0;
            line_len = HT;
            if (jitter && $urandom_range(0, 15) == 0)
                line_len = ($urandom_range(0, 1) != 0) ? HT + 1 : HT - 1;
            gen_v++;
            if (gen_v >= frame_lines) begin
                gen_v = 0;
                frame_lines = VT;
                if (jitter && $urandom_range(0, 7) == 0)
                    frame_lines = ($urandom_range(0, 1) != 0) ? VT + 1 : VT - 1;
            end
        end
    endtask

    task automatic model_reset();
        cyc = 0; h_start = 0; lines = 0; phase = -1; m_err = 0;
        m_hs_prev = 0; m_vs_prev = 0; m_h_seen = 0; m_sync_err = 0;
    endtask

    task automatic model_step(input bit hs_a, input bit vs_a);
        bit hs_e, vs_e, fail;
        hs_e = hs_a && !m_hs_prev;
        vs_e = vs_a && !m_vs_prev;
        // A period is good when the edge lands exactly one raster length after the last.
        fail = (hs_e && (cyc + 1 - h_start != HT)) || (vs_e && (lines + 1 != VT)) ||
               (cyc - h_start >= 2 * HT - 1) || (lines >= 2 * VT - 1);
        m_sync_err = 0;
        if (phase < 0) begin
            if (vs_e && m_h_seen) phase = 0;
        end else if (fail) begin
            if (phase == LF) begin
                m_sync_err = 1;
                if (m_err < 65535) m_err++;
            end
            phase = -1;
        end else if (vs_e && phase < LF) begin
            phase++;
        end
        if (hs_e) m_h_seen = 1;
        if (vs_e) vs_edges++;
        cyc++;
        if (hs_e) h_start = cyc;
        if (vs_e) lines = 0;
        else if (hs_e) lines++;
        m_hs_prev = hs_a;
        m_vs_prev = vs_a;
    endtask

    task automatic check_all();
        int h_now, v_now, ex, ey, ee;
        bit lk, act;
        h_now = (cyc - h_start > 4095) ? 4095 : cyc - h_start;
        v_now = (lines > 2047) ? 2047 : lines;
        lk  = (phase == LF);
        act = lk && h_now >= HOFF && h_now < HOFF + HV && v_now >= VOFF && v_now < VOFF + VV;
        ex  = act ? h_now - HOFF : 0;
        ey  = act ? v_now - VOFF : 0;
`ifdef VGA_DEC_ERR_CNT_EN
        ee = m_err;
`else
        ee = 0;
`endif
        check_output("x", x, ex);
        check_output("y", y, ey);
        check_output("video_active", video_active, act);
        check_output("frame_start", frame_start, act && ex == 0 && ey == 0);
        check_output("locked", locked, lk);
        check_output("sync_error", sync_error, m_sync_err);
        check_output("err_count", err_count, ee);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step(hs_drv, vs_drv);
            #1;
            check_all();
            advance_gen();
            drive_pins();
        end
    endtask

    task automatic wait_lock(input string tag, input int budget);
        for (int i = 0; i < budget && locked !== 1'b1; i++) run_cycles(1);
        check_output(tag, locked, 1);
    endtask

    initial begin
        // Start away from any sync pulse and before the last line so the first
        // hsync edge strictly precedes the first vsync edge.
        gen_h = $urandom_range(HS, HT - 1);
        gen_v = $urandom_range(VS, VT - 2);
        line_len = HT; frame_lines = VT; hold_h = 0; jitter = 0;
        drive_pins();
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 check_all();
        end
        rst_n = 1'b1;

        // Nominal stream: lock on the third vsync edge, then free-run.
        vs_edges = 0;
        for (int i = 0; i < 6 * HT * VT && locked !== 1'b1; i++) run_cycles(1);
        check_output("lock_vs_edges", vs_edges, 3);
        check_output("lock_rise", locked, 1);
        run_cycles(2 * HT * VT);

        // One short line mid-frame while locked.
        for (int i = 0; i < 2 * HT * VT && !(gen_v == VOFF + 2 && gen_h == 1); i++) run_cycles(1);
        line_len = HT - 1;
        for (int i = 0; i < 2 * HT && !m_sync_err; i++) run_cycles(1);
        check_output("short_line_sync_error", sync_error, 1);
        check_output("short_line_unlocked", locked, 0);
        wait_lock("relock_after_short_line", 6 * HT * VT);

        // hsync stuck deasserted until the line timeout fires.
        hold_h = 1;
        for (int i = 0; i < 2 * HT + 5 && !m_sync_err; i++) run_cycles(1);
        check_output("h_timeout_sync_error", sync_error, 1);
        check_output("h_timeout_unlocked", locked, 0);
        hold_h = 0;

        // A frame one line short while acquiring drops back quietly.
        for (int i = 0; i < 4 * HT * VT && phase != 0; i++) run_cycles(1);
        frame_lines = VT - 1;
        for (int i = 0; i < 2 * HT * VT && phase >= 0; i++) run_cycles(1);
        check_output("short_frame_no_sync_error", sync_error, 0);
        check_output("short_frame_unlocked", locked, 0);
        vs_edges = 0;
        for (int i = 0; i < 6 * HT * VT && locked !== 1'b1; i++) run_cycles(1);
        check_output("relock_vs_edges", vs_edges, 3);

        // Asynchronous reset at a random point while locked.
        run_cycles($urandom_range(20, HT * VT));
        rst_n = 1'b0;
        model_reset();
        #1 check_all();
        repeat (2) begin
            @(posedge clk);
            #1 check_all();
            advance_gen();
            drive_pins();
        end
        rst_n = 1'b1;
        wait_lock("relock_after_reset", 6 * HT * VT);

        // Randomly perturbed line and frame lengths.
        jitter = 1;
        run_cycles(12 * HT * VT);
        jitter = 0;
        wait_lock("relock_after_jitter", 8 * HT * VT);
        run_cycles(HT * VT);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
